// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// RV32I memory stage: load/store over a req/gnt/rvalid bus with byte-lane
// alignment, load extension, stall generation and a registered writeback word.
module mem_access_stage #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_BITS  = $clog2(REG_COUNT),
  parameter int CTRL_W    = 14,
  parameter int TIMEOUT   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REG_BITS+CTRL_W+3*REG_WIDTH:0]  exc_mem_reg,
  input  logic                                  in_valid,
  output logic                                  stall,
  output logic                                  dmem_req,
  output logic                                  dmem_we,
  output logic [31:0]                           dmem_addr,
  output logic [3:0]                            dmem_be,
  output logic [31:0]                           dmem_wdata,
  input  logic                                  dmem_gnt,
  input  logic                                  dmem_rvalid,
  input  logic [31:0]                           dmem_rdata,
  output logic [REG_BITS+REG_WIDTH:0]           mem_wb_reg,
  output logic                                  wb_valid,
  output logic                                  misalign,
  output logic                                  bus_err
);

  localparam int EX_W = REG_BITS + 1 + CTRL_W + 3*REG_WIDTH;

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{lane[7]}},  lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b100:  return {24'h0, lane[7:0]};
      3'b101:  return {16'h0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   return {4{rs2[7:0]}};
      2'b01:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  logic [REG_BITS-1:0]  rd;
  logic                 write_en;
  logic [CTRL_W-1:0]    ctrl;
  logic [REG_WIDTH-1:0] alu_out, rs2_data, return_pc;
  logic                 mem_read, mem_write, memop, fault, bad_f3, bad_align;
  logic [2:0]           funct3;
  logic [1:0]           wb_sel, off;
  logic                 unused_ctrl;

  assign rd        = exc_mem_reg[EX_W-1 -: REG_BITS];
  assign write_en  = exc_mem_reg[3*REG_WIDTH+CTRL_W];
  assign ctrl      = exc_mem_reg[3*REG_WIDTH +: CTRL_W];
  assign alu_out   = exc_mem_reg[3*REG_WIDTH-1 -: REG_WIDTH];
  assign rs2_data  = exc_mem_reg[2*REG_WIDTH-1 -: REG_WIDTH];
  assign return_pc = exc_mem_reg[REG_WIDTH-1:0];

  assign mem_read    = ctrl[13];
  assign mem_write   = ctrl[12];
  assign funct3      = ctrl[11:9];
  assign wb_sel      = ctrl[8:7];
  assign unused_ctrl = ^ctrl[6:0];
  assign off         = alu_out[1:0];
  assign memop       = mem_read | mem_write;

  // Illegal widths and both-direction ops are folded into the alignment fault.
  assign bad_f3    = mem_read ? (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                              : (funct3 > 3'b010);
  assign bad_align = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
  assign fault     = memop & ((mem_read & mem_write) | bad_f3 | bad_align);

  state_t     state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       done_p0, timeout_p0, we_eff_p0;
  logic [31:0] wb_data_p0;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    done_p0    = 1'b0;
    timeout_p0 = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!memop || fault) begin
            done_p0 = 1'b1;
          end else if (dmem_gnt) begin
            if (mem_write) begin
              done_p0 = 1'b1;
            end else begin
              state_nxt = WAIT;
              cnt_nxt   = 5'd0;
            end
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          done_p0   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == 5'(TIMEOUT-1)) begin
          done_p0    = 1'b1;
          timeout_p0 = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall      = in_valid & memop & ~fault & ~done_p0;
  assign dmem_req   = ~rst & (state == IDLE) & in_valid & memop & ~fault;
  assign dmem_we    = dmem_req & mem_write;
  assign dmem_addr  = {alu_out[31:2], 2'b00};
  assign dmem_be    = mem_write ? store_be(funct3[1:0], off) : 4'b1111;
  assign dmem_wdata = store_wdata(funct3[1:0], rs2_data);

  assign we_eff_p0  = write_en & ~fault & ~timeout_p0;
  assign wb_data_p0 = (wb_sel == 2'b01) ? load_extend(dmem_rdata, off, funct3) :
                      (wb_sel == 2'b10) ? return_pc : alu_out;

  // Stage boundary: memory -> writeback register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      mem_wb_reg <= '0;
      wb_valid   <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wb_valid <= done_p0;
      misalign <= done_p0 & fault;
      bus_err  <= timeout_p0;
      if (done_p0) mem_wb_reg <= {rd, we_eff_p0, wb_data_p0};
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
// Directed bench for mem_access_stage: table of single-cycle ops plus
// hand-written multi-cycle load, store-wait, timeout and reset sequences.
module tb_mem_access_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [115:0] exc_mem_reg;
  logic         in_valid, stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]   dmem_be;
  logic [37:0]  mem_wb_reg;
  logic         wb_valid, misalign, bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .exc_mem_reg(exc_mem_reg), .in_valid(in_valid),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_wb_reg(mem_wb_reg),
    .wb_valid(wb_valid), .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        we, mr, mw;
    logic [2:0]  f3;
    logic [1:0]  ws;
    logic [31:0] alu, rs2;
    logic        gnt;
    logic        ereq;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
    logic        ewe;
    logic [31:0] ewb;
    logic        emis;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [115:0] pk(input logic [4:0] rd, input logic we, input logic mr,
                                      input logic mw, input logic [2:0] f3, input logic [1:0] ws,
                                      input logic [31:0] alu, input logic [31:0] rs2);
    return {rd, we, mr, mw, f3, ws, 7'b0, alu, rs2, 32'h0000_2004};
  endfunction

  function automatic vec_t v(input logic [4:0] rd, input logic we, input logic mr, input logic mw,
                             input logic [2:0] f3, input logic [1:0] ws, input logic [31:0] alu,
                             input logic [31:0] rs2, input logic gnt, input logic ereq,
                             input logic [3:0] ebe, input logic [31:0] ewdata, input logic ewe,
                             input logic [31:0] ewb, input logic emis);
    vec_t r;
    r.rd = rd; r.we = we; r.mr = mr; r.mw = mw; r.f3 = f3; r.ws = ws; r.alu = alu; r.rs2 = rs2;
    r.gnt = gnt; r.ereq = ereq; r.ebe = ebe; r.ewdata = ewdata; r.ewe = ewe; r.ewb = ewb;
    r.emis = emis;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_alu(input string nm, input logic [4:0] rd, input logic [31:0] alu);
    exc_mem_reg = pk(rd, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, alu, 32'h0);
    in_valid = 1'b1;
    #4;
    chk({nm, "_stall"}, 64'(stall), 64'd0);
    chk({nm, "_req"}, 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_wbv"}, 64'(wb_valid), 64'd1);
    chk({nm, "_wb"}, 64'(mem_wb_reg), 64'({rd, 1'b1, alu}));
    in_valid = 1'b0;
  endtask

  // gd: cycles without gnt before the grant; rvd: WAIT cycles without rvalid.
  task automatic do_load(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] ws, input logic [31:0] alu, input int gd,
                         input int rvd, input logic [31:0] rword, input int exp_stall,
                         input logic [37:0] exp_wb, input logic exp_berr);
    int stalls = 0;
    bit done = 1'b0;
    exc_mem_reg = pk(rd, 1'b1, 1'b1, 1'b0, f3, ws, alu, 32'h0);
    in_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_gnt = (c == gd);
      if (c <= gd) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
      end else begin
        dmem_rvalid = (c == gd + 1 + rvd);
        dmem_rdata  = dmem_rvalid ? rword : 32'hDEAD_BEEF;
      end
      #4;
      if (stall) stalls++;
      if (c == 0) begin
        chk({nm, "_req"}, 64'(dmem_req), 64'd1);
        chk({nm, "_we"}, 64'(dmem_we), 64'd0);
        chk({nm, "_be"}, 64'(dmem_be), 64'hF);
        chk({nm, "_addr"}, 64'(dmem_addr), 64'({alu[31:2], 2'b00}));
      end
      if (c == gd + 1) chk({nm, "_req_wait"}, 64'(dmem_req), 64'd0);
      @(posedge clk); #1;
      if (wb_valid) begin
        done = 1'b1;
        chk({nm, "_wb"}, 64'(mem_wb_reg), 64'(exp_wb));
        chk({nm, "_buserr"}, 64'(bus_err), 64'(exp_berr));
        chk({nm, "_misalign"}, 64'(misalign), 64'd0);
      end
    end
    chk({nm, "_completed"}, 64'(done), 64'd1);
    chk({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
    in_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  initial begin
    // rd we mr mw f3 ws alu rs2 gnt | req be wdata we_eff wb_data misalign
    tbl[0]  = v(5, 1, 0, 0, 3'b000, 2'b00, 32'h1234, 32'h0, 0, 0, 4'h0, 32'h0, 1, 32'h1234, 0);
    tbl[1]  = v(1, 1, 0, 0, 3'b000, 2'b10, 32'h40, 32'h0, 0, 0, 4'h0, 32'h0, 1, 32'h2004, 0);
    tbl[2]  = v(2, 1, 0, 0, 3'b000, 2'b11, 32'h55AA, 32'h0, 0, 0, 4'h0, 32'h0, 1, 32'h55AA, 0);
    tbl[3]  = v(0, 0, 0, 1, 3'b000, 2'b00, 32'h103, 32'hAABBCCDD, 1, 1, 4'b1000, 32'hDDDDDDDD, 0, 32'h103, 0);
    tbl[4]  = v(0, 0, 0, 1, 3'b001, 2'b00, 32'h102, 32'h11223344, 1, 1, 4'b1100, 32'h33443344, 0, 32'h102, 0);
    tbl[5]  = v(0, 0, 0, 1, 3'b010, 2'b00, 32'h200, 32'hCAFEBABE, 1, 1, 4'b1111, 32'hCAFEBABE, 0, 32'h200, 0);
    tbl[6]  = v(0, 0, 0, 1, 3'b000, 2'b00, 32'h101, 32'h000000EE, 1, 1, 4'b0010, 32'hEEEEEEEE, 0, 32'h101, 0);
    tbl[7]  = v(7, 1, 1, 0, 3'b010, 2'b01, 32'h6, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h0, 1);
    tbl[8]  = v(3, 1, 0, 1, 3'b001, 2'b00, 32'h101, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h101, 1);
    tbl[9]  = v(4, 1, 1, 0, 3'b011, 2'b00, 32'h8, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h8, 1);
    tbl[10] = v(0, 0, 0, 1, 3'b100, 2'b00, 32'h10, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h10, 1);
    tbl[11] = v(6, 1, 1, 1, 3'b010, 2'b00, 32'h20, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h20, 1);
    tbl[12] = v(2, 1, 1, 0, 3'b110, 2'b00, 32'h30, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h30, 1);

    rst = 1'b0; in_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    exc_mem_reg = pk(5'd1, 1'b0, 1'b0, 1'b1, 3'b010, 2'b00, 32'h80, 32'h1);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    #2;
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_wbv", 64'(wb_valid), 64'd0);
    chk("rst_wb", 64'(mem_wb_reg), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_buserr", 64'(bus_err), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    for (int i = 0; i < 13; i++) begin
      vec_t t;
      t = tbl[i];
      exc_mem_reg = pk(t.rd, t.we, t.mr, t.mw, t.f3, t.ws, t.alu, t.rs2);
      in_valid = 1'b1; dmem_gnt = t.gnt; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      #4;
      chk($sformatf("v%0d_req", i), 64'(dmem_req), 64'(t.ereq));
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'd0);
      chk($sformatf("v%0d_addr", i), 64'(dmem_addr), 64'({t.alu[31:2], 2'b00}));
      if (t.ereq) begin
        chk($sformatf("v%0d_we", i), 64'(dmem_we), 64'(t.mw));
        chk($sformatf("v%0d_be", i), 64'(dmem_be), 64'(t.ebe));
        chk($sformatf("v%0d_wdata", i), 64'(dmem_wdata), 64'(t.ewdata));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_wbv", i), 64'(wb_valid), 64'd1);
      chk($sformatf("v%0d_wb", i), 64'(mem_wb_reg), 64'({t.rd, t.ewe, t.ewb}));
      chk($sformatf("v%0d_misalign", i), 64'(misalign), 64'(t.emis));
      chk($sformatf("v%0d_buserr", i), 64'(bus_err), 64'd0);
      in_valid = 1'b0; dmem_gnt = 1'b0;
    end

    @(posedge clk); #1;
    chk("idle_wbv", 64'(wb_valid), 64'd0);
    chk("idle_misalign", 64'(misalign), 64'd0);
    chk("idle_hold", 64'(mem_wb_reg), 64'({tbl[12].rd, 1'b0, tbl[12].ewb}));

    // Store held for two cycles without grant.
    exc_mem_reg = pk(5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 2'b00, 32'h206, 32'h0000BEEF);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dmem_gnt = (c == 2);
      #4;
      chk($sformatf("sh_wait%0d_req", c), 64'(dmem_req), 64'd1);
      chk($sformatf("sh_wait%0d_addr", c), 64'(dmem_addr), 64'h204);
      chk($sformatf("sh_wait%0d_be", c), 64'(dmem_be), 64'b1100);
      chk($sformatf("sh_wait%0d_wdata", c), 64'(dmem_wdata), 64'hBEEFBEEF);
      chk($sformatf("sh_wait%0d_stall", c), 64'(stall), 64'(c != 2));
      @(posedge clk); #1;
      chk($sformatf("sh_wait%0d_wbv", c), 64'(wb_valid), 64'(c == 2));
    end
    in_valid = 1'b0; dmem_gnt = 1'b0;

    do_load("lh",  5'd9,  3'b001, 2'b01, 32'h102, 2, 3, 32'h8001_7FFF, 6, {5'd9, 1'b1, 32'hFFFF_8001}, 1'b0);
    do_load("lhu", 5'd9,  3'b101, 2'b01, 32'h102, 0, 0, 32'h8001_7FFF, 1, {5'd9, 1'b1, 32'h0000_8001}, 1'b0);
    do_load("lb",  5'd11, 3'b000, 2'b01, 32'h101, 1, 0, 32'h0000_8000, 2, {5'd11, 1'b1, 32'hFFFF_FF80}, 1'b0);
    do_load("lbu", 5'd12, 3'b100, 2'b01, 32'h103, 0, 1, 32'h9A00_0000, 2, {5'd12, 1'b1, 32'h0000_009A}, 1'b0);
    do_load("lw",  5'd13, 3'b010, 2'b01, 32'h104, 0, 2, 32'h1234_5678, 3, {5'd13, 1'b1, 32'h1234_5678}, 1'b0);
    do_load("tmo", 5'd4,  3'b010, 2'b00, 32'h20,  0, 100, 32'h0, 16, {5'd4, 1'b0, 32'h20}, 1'b1);

    // Late rvalid after the timeout must be ignored.
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    #4;
    chk("late_req", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
    chk("late_wbv", 64'(wb_valid), 64'd0);
    chk("late_buserr", 64'(bus_err), 64'd0);
    dmem_rvalid = 1'b0;
    do_alu("post_tmo_add", 5'd14, 32'h77);

    // Reset while a load is waiting for rvalid.
    exc_mem_reg = pk(5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h40, 32'h0);
    in_valid = 1'b1; dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstw_req", 64'(dmem_req), 64'd0);
    chk("rstw_wb", 64'(mem_wb_reg), 64'd0);
    chk("rstw_wbv", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h2222_2222;
    @(posedge clk); #1;
    chk("rstw_late_wbv", 64'(wb_valid), 64'd0);
    dmem_rvalid = 1'b0;
    do_alu("post_rst_add", 5'd10, 32'hABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Consumes the execute→memory pipeline word and performs loads and stores over a req/gnt/rvalid data-memory interface.
- Handles byte-lane alignment, load sign/zero extension and multi-cycle stalls.
- Produces the registered memory→writeback word {rd, write_en, wb_data}.

Parameters:
- REG_WIDTH, 32, datapath width. Must be 32.
- REG_COUNT, 32, architectural register count.
- REG_BITS, $clog2(REG_COUNT), destination register index width.
- CTRL_W, 14, control bits carried from execute.
- TIMEOUT, 16, max cycles in WAIT before bus error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- exc_mem_reg  in  REG_BITS+1+CTRL_W+3*REG_WIDTH  {rd, write_en, ctrl[13:0], alu_out, rs2_data, return_pc}.
- in_valid  in  1  exc_mem_reg holds a live instruction.
- stall  out  1  combinational; upstream holds exc_mem_reg stable while 1.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=store.
- dmem_addr  out  32  {alu_out[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data word.
- mem_wb_reg  out  REG_BITS+1+REG_WIDTH  {rd, write_en, wb_data}.
- wb_valid  out  1  mem_wb_reg updated last edge.
- misalign  out  1  registered one-cycle fault pulse.
- bus_err  out  1  registered one-cycle timeout pulse.

Behaviour:
- Ctrl field map:
  - ctrl[13] = mem_read; ctrl[12] = mem_write.
  - ctrl[11:9] = funct3.
  - ctrl[8:7] = wb_sel: 00 alu_out, 01 load data, 10 return_pc, 11 alu_out.
  - ctrl[6:4] = branch_type, ignored here; ctrl[3:0] reserved.
- memop = mem_read | mem_write. Both set = fault, handled as misalign.
- Fault conditions (fault=1), no memory request issued:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - Load funct3 ∈ {011,110,111}; store funct3 > 010.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
  - Loads drive be = 1111.
- Load extract: lane = dmem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- FSM states IDLE, WAIT. 5-bit cycle counter cnt.
  - dmem_req = ~rst & state==IDLE & in_valid & memop & ~fault.
  - IDLE, store, gnt=1: store completes this cycle.
  - IDLE, load, gnt=1: go to WAIT, cnt<=0.
  - IDLE, gnt=0: remain in IDLE; request and outputs held.
  - WAIT, rvalid=1: load completes; go to IDLE.
  - WAIT, cnt==TIMEOUT-1 and rvalid=0: timeout completion; go to IDLE; bus_err<=1.
  - WAIT otherwise: cnt<=cnt+1.
- dmem_rvalid is sampled only in WAIT; ignored in IDLE, including same cycle as gnt.
- stall = in_valid & memop & ~fault & ~complete_this_cycle.
- Non-memory op or fault: stall=0, completes in the same cycle.
- Completion edge:
  - mem_wb_reg <= {rd, write_en_eff, wb_data}; wb_valid <= 1.
  - write_en_eff = write_en & ~fault & ~timeout.
  - misalign <= fault.
- Other edges: wb_valid <= 0, misalign <= 0, bus_err <= 0; mem_wb_reg holds.
- Latency:
  - Non-mem or fault: 1 cycle.
  - Store: 1 + gnt wait.
  - Load: ≥2 cycles (gnt, then rvalid).
- Reset:
  - state=IDLE, cnt=0.
  - mem_wb_reg, wb_valid, misalign, bus_err all 0.
  - dmem_req forced 0 while rst=1.
  - Reset in WAIT abandons the load; a late rvalid is ignored.

Test Plan:
- ADD, wb_sel=00, alu_out=0x1234, rd=5, in_valid=1 → next edge mem_wb_reg={5,1,0x1234}, wb_valid=1, stall never 1.
- SB rs2=0xAABBCCDD, addr=0x103, gnt on first cycle → be=1000, wdata=0xDDDDDDDD, dmem_addr=0x100, stall=0, write_en_eff=0.
- LH addr=0x102, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x8001_7FFF → stall high for 6 cycles, wb_data=0xFFFF8001; LHU same → 0x00008001.
- LW addr=0x06 → no dmem_req, misalign pulse 1 cycle, wb_valid=1 with write_en=0, stall=0.
- LW, gnt, no rvalid → after TIMEOUT=16 WAIT cycles bus_err pulses, write_en=0, FSM back to IDLE; a late rvalid is ignored.
- Assert rst in WAIT → dmem_req=0 and outputs zero immediately; after release, the next ADD completes normally in 1 cycle.
